head_gbus_arbiter: RTL and testbench

//  Downstream of each core's out_gbus port. Merges CORE_NUM per-core write-only gbus streams
//  (addr/wen/wdata, no backpressure from cores) into one head-level gbus write stream.

---
 rtl/head_gbus_arbiter_pkg.sv | 14 +
 rtl/head_gbus_arbiter_if.sv | 37 +++
 rtl/gbus_arb_fifo.sv | 65 ++++++
 rtl/head_gbus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_head_gbus_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/head_gbus_arbiter_pkg.sv
// Shared gbus definitions: widths, per-write bundle.
// Imported by core_top and head-level gbus blocks.
package head_gbus_arbiter_pkg;

  localparam int GBUS_ADDR_WIDTH     = 19;
  localparam int GBUS_DATA_WIDTH     = 32;
  localparam int BUS_CORE_ADDR_WIDTH = 13;

  typedef struct packed {
    logic [GBUS_ADDR_WIDTH-1:0] addr;
    logic [GBUS_DATA_WIDTH-1:0] data;
  } gbus_wr_t;

endpackage

// File: rtl/head_gbus_arbiter_if.sv
// Gbus merge bundle: packed per-core write inputs,
// downstream stall and merged head write outputs.
interface head_gbus_arbiter_if
  import head_gbus_arbiter_pkg::*;
#(
  parameter int CORE_NUM = 16
);

  logic [CORE_NUM*GBUS_ADDR_WIDTH-1:0] core_gbus_addr;
  logic [CORE_NUM-1:0]                 core_gbus_wen;
  logic [CORE_NUM*GBUS_DATA_WIDTH-1:0] core_gbus_wdata;
  logic                                head_gbus_stall;
  logic [GBUS_ADDR_WIDTH-1:0]          head_gbus_addr;
  logic                                head_gbus_wen;
  logic [GBUS_DATA_WIDTH-1:0]          head_gbus_wdata;

  modport master (
    output core_gbus_addr,
    output core_gbus_wen,
    output core_gbus_wdata,
    output head_gbus_stall,
    input  head_gbus_addr,
    input  head_gbus_wen,
    input  head_gbus_wdata
  );

  modport slave (
    input  core_gbus_addr,
    input  core_gbus_wen,
    input  core_gbus_wdata,
    input  head_gbus_stall,
    output head_gbus_addr,
    output head_gbus_wen,
    output head_gbus_wdata
  );

endinterface

// File: rtl/gbus_arb_fifo.sv
// Per-core write buffer: DEPTH-entry circular FIFO.
// Ports: push/pop/flush in, head entry, full/empty/drop out.
module gbus_arb_fifo
  import head_gbus_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  gbus_wr_t wr_i,
  output gbus_wr_t rd_o,
  output logic     full_o,
  output logic     empty_o,
  output logic     drop_o
);

  localparam int PW = $clog2(DEPTH);

  gbus_wr_t      mem_q [DEPTH];
  logic [PW:0]   wp_q, wp_d;
  logic [PW:0]   rp_q, rp_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[PW] != rp_q[PW]) &&
                   (wp_q[PW-1:0] == rp_q[PW-1:0]);

  // A pop on the same edge frees the slot a full push needs.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok && !flush_i;
  assign rd_o    = mem_q[rp_q[PW-1:0]];

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (flush_i) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + 1'b1;
      if (pop_ok)  rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i)
      mem_q[wp_q[PW-1:0]] <= wr_i;
  end

endmodule

// File: rtl/head_gbus_arbiter.sv
// Merges CORE_NUM buffered core gbus write streams into one
// round-robin head stream. Ports: clk, rstn, flush, bus
// (slave), ovf_sticky, busy; HEAD_GBUS_ARB_PERF_EN adds
// perf_grant_cnt / perf_stall_cnt.
module head_gbus_arbiter
  import head_gbus_arbiter_pkg::*;
#(
  parameter int CORE_NUM   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  head_gbus_arbiter_if.slave  bus,
  output logic [CORE_NUM-1:0] ovf_sticky,
`ifdef HEAD_GBUS_ARB_PERF_EN
  output logic [31:0]         perf_grant_cnt,
  output logic [31:0]         perf_stall_cnt,
`endif
  output logic                busy
);

  localparam int AW = GBUS_ADDR_WIDTH;
  localparam int DW = GBUS_DATA_WIDTH;
  localparam int PW = $clog2(CORE_NUM);

  gbus_wr_t            fifo_wr [CORE_NUM];
  gbus_wr_t            fifo_rd [CORE_NUM];
  logic [CORE_NUM-1:0] empty;
  logic [CORE_NUM-1:0] full;
  logic [CORE_NUM-1:0] drop;
  logic [CORE_NUM-1:0] pop;
  logic [CORE_NUM-1:0] ne;

  logic [PW-1:0]       rr_q, rr_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       data_q, data_d;
  logic                wen_q, wen_d;
  logic [CORE_NUM-1:0] ovf_q, ovf_d;

  for (genvar g = 0; g < CORE_NUM; g++) begin : g_fifo
    assign fifo_wr[g] = '{
      addr: bus.core_gbus_addr[g*AW +: AW],
      data: bus.core_gbus_wdata[g*DW +: DW]
    };

    gbus_arb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rstn),
      .flush_i (flush),
      .push_i  (bus.core_gbus_wen[g]),
      .pop_i   (pop[g]),
      .wr_i    (fifo_wr[g]),
      .rd_o    (fifo_rd[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .drop_o  (drop[g])
    );
  end

  assign ne = ~empty;

  // Rotate so rr_q sits at bit 0, pick lowest set bit,
  // then rotate the offset back to a core index.
  logic [2*CORE_NUM-1:0] dbl;
  logic [CORE_NUM-1:0]   rot;
  logic [PW-1:0]         off;
  logic                  hit;
  logic [PW:0]           sum;
  logic [PW-1:0]         win;
  logic                  grant;

  assign dbl = {ne, ne} >> rr_q;
  assign rot = dbl[CORE_NUM-1:0];

  always_comb begin
    off = '0;
    hit = 1'b0;
    for (int i = CORE_NUM-1; i >= 0; i--) begin
      if (rot[i]) begin
        off = PW'(i);
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= (PW+1)'(CORE_NUM))
      sum = sum - (PW+1)'(CORE_NUM);
  end

  assign win   = sum[PW-1:0];
  assign grant = hit && !bus.head_gbus_stall;

  always_comb begin
    pop = '0;
    if (grant) pop[win] = 1'b1;
  end

  always_comb begin
    rr_d   = rr_q;
    addr_d = addr_q;
    data_d = data_q;
    wen_d  = 1'b0;
    ovf_d  = ovf_q | drop;
    if (flush) begin
      rr_d   = '0;
      addr_d = '0;
      data_d = '0;
      ovf_d  = '0;
    end else if (grant) begin
      addr_d = fifo_rd[win].addr;
      data_d = fifo_rd[win].data;
      wen_d  = 1'b1;
      if (win == PW'(CORE_NUM-1))
        rr_d = '0;
      else
        rr_d = win + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
      wen_q  <= 1'b0;
      ovf_q  <= '0;
    end else begin
      rr_q   <= rr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wen_q  <= wen_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.head_gbus_addr  = addr_q;
  assign bus.head_gbus_wdata = data_q;
  assign bus.head_gbus_wen   = wen_q;
  assign ovf_sticky          = ovf_q;
  assign busy                = (|ne) || wen_q;

`ifdef HEAD_GBUS_ARB_PERF_EN
  logic [31:0] pg_q, pg_d;
  logic [31:0] ps_q, ps_d;

  always_comb begin
    pg_d = pg_q;
    ps_d = ps_q;
    if (flush) begin
      pg_d = '0;
      ps_d = '0;
    end else begin
      if (grant && pg_q != '1)
        pg_d = pg_q + 32'd1;
      if (bus.head_gbus_stall && (|ne) && ps_q != '1)
        ps_d = ps_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pg_q <= '0;
      ps_q <= '0;
    end else begin
      pg_q <= pg_d;
      ps_q <= ps_d;
    end
  end

  assign perf_grant_cnt = pg_q;
  assign perf_stall_cnt = ps_q;
`endif

endmodule

// File: tb/tb_head_gbus_arbiter.sv
// Randomized + directed bench for head_gbus_arbiter
// against a queue-based reference model.
module tb_head_gbus_arbiter;
  import head_gbus_arbiter_pkg::*;

  localparam int N  = 16;
  localparam int D  = 4;
  localparam int AW = GBUS_ADDR_WIDTH;
  localparam int DW = GBUS_DATA_WIDTH;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic [N-1:0]  ovf;
  logic          busy;
`ifdef HEAD_GBUS_ARB_PERF_EN
  logic [31:0]   pg;
  logic [31:0]   ps;
`endif

  head_gbus_arbiter_if #(.CORE_NUM(N)) bus();

  head_gbus_arbiter #(
    .CORE_NUM   (N),
    .FIFO_DEPTH (D)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .flush          (flush),
    .bus            (bus),
    .ovf_sticky     (ovf),
`ifdef HEAD_GBUS_ARB_PERF_EN
    .perf_grant_cnt (pg),
    .perf_stall_cnt (ps),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one queue per core, plain rules.
  gbus_wr_t      mq [N][$];
  int            m_rr;
  logic          m_wen;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_ovf;
  longint        m_gc;
  longint        m_sc;

  task automatic model_clear();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr   = 0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_ovf  = '0;
    m_gc   = 0;
    m_sc   = 0;
  endtask

  function automatic bit model_any();
    for (int i = 0; i < N; i++)
      if (mq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_edge();
    int       w;
    gbus_wr_t e;
    if (!rstn) begin
      model_clear();
      return;
    end
    if (flush) begin
      model_clear();
      return;
    end
    w = -1;
    if (bus.head_gbus_stall && model_any()) m_sc++;
    if (!bus.head_gbus_stall) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && mq[(m_rr + k) % N].size() > 0)
          w = (m_rr + k) % N;
      end
    end
    if (w >= 0) begin
      e      = mq[w].pop_front();
      m_addr = e.addr;
      m_data = e.data;
      m_wen  = 1'b1;
      m_rr   = (w + 1) % N;
      m_gc++;
    end else begin
      m_wen = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.core_gbus_wen[i]) begin
        e.addr = bus.core_gbus_addr[i*AW +: AW];
        e.data = bus.core_gbus_wdata[i*DW +: DW];
        if (mq[i].size() < D) mq[i].push_back(e);
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("wen",  64'(bus.head_gbus_wen),   64'(m_wen));
    chk("addr", 64'(bus.head_gbus_addr),  64'(m_addr));
    chk("data", 64'(bus.head_gbus_wdata), 64'(m_data));
    chk("ovf",  64'(ovf),                 64'(m_ovf));
    chk("busy", 64'(busy),
        64'(model_any() || m_wen));
`ifdef HEAD_GBUS_ARB_PERF_EN
    chk("perf_grant", 64'(pg), 64'(m_gc));
    chk("perf_stall", 64'(ps), 64'(m_sc));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    bus.core_gbus_wen = '0;
  endtask

  task automatic put(input int i,
                     input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    bus.core_gbus_wen[i]           = 1'b1;
    bus.core_gbus_addr[i*AW +: AW] = a;
    bus.core_gbus_wdata[i*DW +: DW] = d;
  endtask

  task automatic drain(input int n);
    idle();
    bus.head_gbus_stall = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic load3();
    bus.head_gbus_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      idle();
      put(1, 19'h0_2100 + 19'(k), 32'h1100_0000 + k);
      put(5, 19'h0_A100 + 19'(k), 32'h5500_0000 + k);
      put(9, 19'h1_2100 + 19'(k), 32'h9900_0000 + k);
      step();
    end
    idle();
  endtask

  int dens;

  initial begin
    rstn                = 1'b0;
    flush               = 1'b0;
    bus.core_gbus_wen   = '0;
    bus.core_gbus_addr  = '0;
    bus.core_gbus_wdata = '0;
    bus.head_gbus_stall = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("rst_wen",  64'(bus.head_gbus_wen),  64'd0);
    chk("rst_addr", 64'(bus.head_gbus_addr), 64'd0);
    chk("rst_ovf",  64'(ovf),                64'd0);
    chk("rst_busy", 64'(busy),               64'd0);
    rstn = 1'b1;

    // single core stream
    for (int k = 0; k < 5; k++) begin
      idle();
      put(1, 19'h0_2010 + 19'(k), 32'hA5A5_0000 + k);
      step();
    end
    drain(3);
    chk("s1_busy", 64'(busy), 64'd0);

    // all cores at once, rr from 0
    idle();
    for (int i = 0; i < N; i++)
      put(i, {2'b00, 4'(i), 13'h0040}, 32'hC000_0000 + i);
    step();
    drain(18);

    // stall overflow on core 3
    bus.head_gbus_stall = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle();
      put(3, 19'h0_6000 + 19'(k), 32'h3333_0000 + k);
      step();
    end
    chk("s3_ovf", 64'(ovf), 64'h0008);
    drain(6);

    // flush with three loaded FIFOs
    load3();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_ovf",  64'(ovf),                64'd0);
    chk("fl_wen",  64'(bus.head_gbus_wen),  64'd0);
    chk("fl_busy", 64'(busy),               64'd0);
    drain(4);

    // core 7 full, push and pop on the same edge
    bus.head_gbus_stall = 1'b1;
    for (int k = 0; k < D; k++) begin
      idle();
      put(7, 19'h0_E000 + 19'(k), 32'h7777_0000 + k);
      step();
    end
    bus.head_gbus_stall = 1'b0;
    idle();
    put(7, 19'h0_E00F, 32'h7777_00FF);
    step();
    chk("s4_ovf7", 64'(ovf[7]), 64'd0);
    drain(7);

    // async reset with three loaded FIFOs
    load3();
    #2 rstn = 1'b0;
    #1;
    chk("ar_wen",  64'(bus.head_gbus_wen),  64'd0);
    chk("ar_addr", 64'(bus.head_gbus_addr), 64'd0);
    chk("ar_busy", 64'(busy),               64'd0);
    bus.head_gbus_stall = 1'b0;
    step();
    rstn = 1'b1;
    drain(4);

    // randomized traffic
    dens = 6;
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) dens = $urandom_range(1, 25);
      for (int i = 0; i < N; i++) begin
        bus.core_gbus_wen[i] =
          ($urandom_range(0, 99) < dens);
        bus.core_gbus_addr[i*AW +: AW]  = AW'($urandom);
        bus.core_gbus_wdata[i*DW +: DW] = $urandom;
      end
      bus.head_gbus_stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 199) == 0);
      step();
    end
    flush = 1'b0;
    drain(N * D + 4);
    chk("end_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
